// File: rtl/renkon_layer_seq.sv
`default_nettype none
// ============================================================================
// Module  : renkon_layer_seq
// Brief   : Descriptor table plus req/ack layer scheduler for the renkon
//           controller. Optional ack timeout enabled by RENKON_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module renkon_layer_seq #(
  parameter int LAYERS   = 8,
  parameter int LAYERLOG = 3,
  parameter int IMGSIZE  = 12,
  parameter int NETSIZE  = 11,
  parameter int LWIDTH   = 10,
  parameter int TIMEOUT  = 65535
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                cfg_we,
  input  logic [LAYERLOG-1:0] cfg_layer,
  input  logic [2:0]          cfg_field,
  input  logic [15:0]         cfg_wdata,
  input  logic [LAYERLOG:0]   num_layers,
  input  logic                start,
  input  logic                ack,
  output logic                req,
  output logic [IMGSIZE-1:0]  in_offset,
  output logic [IMGSIZE-1:0]  out_offset,
  output logic [NETSIZE-1:0]  net_offset,
  output logic [LWIDTH-1:0]   total_in,
  output logic [LWIDTH-1:0]   total_out,
  output logic [LWIDTH-1:0]   img_size,
  output logic [LWIDTH-1:0]   conv_size,
  output logic [LWIDTH-1:0]   pool_size,
  output logic [LAYERLOG-1:0] layer_idx,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [LAYERLOG:0] C_MAX_LAYERS = LAYERS[LAYERLOG:0];

  // Descriptor table: deliberately not reset, contents valid only once written.
  logic [IMGSIZE-1:0] tbl_in_off  [LAYERS];
  logic [IMGSIZE-1:0] tbl_out_off [LAYERS];
  logic [NETSIZE-1:0] tbl_net_off [LAYERS];
  logic [LWIDTH-1:0]  tbl_tot_in  [LAYERS];
  logic [LWIDTH-1:0]  tbl_tot_out [LAYERS];
  logic [LWIDTH-1:0]  tbl_img     [LAYERS];
  logic [LWIDTH-1:0]  tbl_conv    [LAYERS];
  logic [LWIDTH-1:0]  tbl_pool    [LAYERS];

  logic [2:0]          state_q, state_d;
  logic [LAYERLOG-1:0] idx_q, idx_d;
  logic [LAYERLOG:0]   num_q, num_d;
  logic [IMGSIZE-1:0]  in_offset_q, in_offset_d;
  logic [IMGSIZE-1:0]  out_offset_q, out_offset_d;
  logic [NETSIZE-1:0]  net_offset_q, net_offset_d;
  logic [LWIDTH-1:0]   total_in_q, total_in_d;
  logic [LWIDTH-1:0]   total_out_q, total_out_d;
  logic [LWIDTH-1:0]   img_size_q, img_size_d;
  logic [LWIDTH-1:0]   conv_size_q, conv_size_d;
  logic [LWIDTH-1:0]   pool_size_q, pool_size_d;

  logic tbl_we;
  logic is_last;
  logic unused_ok;

`ifdef RENKON_SEQ_TIMEOUT_EN
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  assign tbl_we    = cfg_we && (state_q == S_IDLE);
  assign is_last   = ({1'b0, idx_q} == (num_q - 1'b1));
  assign unused_ok = &{1'b0, cfg_wdata, TIMEOUT[0]};

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      case (cfg_field)
        3'd0:    tbl_in_off[cfg_layer]  <= cfg_wdata[IMGSIZE-1:0];
        3'd1:    tbl_out_off[cfg_layer] <= cfg_wdata[IMGSIZE-1:0];
        3'd2:    tbl_net_off[cfg_layer] <= cfg_wdata[NETSIZE-1:0];
        3'd3:    tbl_tot_in[cfg_layer]  <= cfg_wdata[LWIDTH-1:0];
        3'd4:    tbl_tot_out[cfg_layer] <= cfg_wdata[LWIDTH-1:0];
        3'd5:    tbl_img[cfg_layer]     <= cfg_wdata[LWIDTH-1:0];
        3'd6:    tbl_conv[cfg_layer]    <= cfg_wdata[LWIDTH-1:0];
        default: tbl_pool[cfg_layer]    <= cfg_wdata[LWIDTH-1:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
`ifdef RENKON_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef RENKON_SEQ_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (num_layers == '0) begin
            state_d = S_FIN;
          end else begin
            num_d   = (num_layers > C_MAX_LAYERS) ? C_MAX_LAYERS : num_layers;
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
`ifdef RENKON_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (ack) begin
          if (is_last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
`ifdef RENKON_SEQ_TIMEOUT_EN
        // Counter equals the number of WAIT cycles already elapsed.
        else if (cnt_q == C_TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_offset_d  = in_offset_q;
    out_offset_d = out_offset_q;
    net_offset_d = net_offset_q;
    total_in_d   = total_in_q;
    total_out_d  = total_out_q;
    img_size_d   = img_size_q;
    conv_size_d  = conv_size_q;
    pool_size_d  = pool_size_q;
    if (state_q == S_LOAD) begin
      in_offset_d  = tbl_in_off[idx_q];
      out_offset_d = tbl_out_off[idx_q];
      net_offset_d = tbl_net_off[idx_q];
      total_in_d   = tbl_tot_in[idx_q];
      total_out_d  = tbl_tot_out[idx_q];
      img_size_d   = tbl_img[idx_q];
      conv_size_d  = tbl_conv[idx_q];
      pool_size_d  = tbl_pool[idx_q];
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      in_offset_q  <= '0;
      out_offset_q <= '0;
      net_offset_q <= '0;
      total_in_q   <= '0;
      total_out_q  <= '0;
      img_size_q   <= '0;
      conv_size_q  <= '0;
      pool_size_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      in_offset_q  <= in_offset_d;
      out_offset_q <= out_offset_d;
      net_offset_q <= net_offset_d;
      total_in_q   <= total_in_d;
      total_out_q  <= total_out_d;
      img_size_q   <= img_size_d;
      conv_size_q  <= conv_size_d;
      pool_size_q  <= pool_size_d;
    end
  end

`ifdef RENKON_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // FIN is not busy so that busy falls together with the done pulse.
  assign req        = (state_q == S_REQ);
  assign done       = (state_q == S_FIN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign layer_idx  = idx_q;
  assign in_offset  = in_offset_q;
  assign out_offset = out_offset_q;
  assign net_offset = net_offset_q;
  assign total_in   = total_in_q;
  assign total_out  = total_out_q;
  assign img_size   = img_size_q;
  assign conv_size  = conv_size_q;
  assign pool_size  = pool_size_q;

endmodule
`default_nettype wire

// File: doc/renkon_layer_seq.md
Name: renkon_layer_seq

Overview:
- Multi-layer scheduler in front of the renkon controller.
- Host preloads a small table of per-layer descriptors, then pulses start.
- Block drives one req/ack transaction per layer, presenting that layer's offsets and sizes as stable configuration inputs to the controller.
- Sits between the host register interface and the renkon control pipeline.

Parameters:
- LAYERS, 8, descriptor table depth (power of two)
- LAYERLOG, 3, log2(LAYERS)
- IMGSIZE, 12, image memory address width
- NETSIZE, 11, network memory address width
- LWIDTH, 10, layer size field width
- TIMEOUT, 65535, max cycles to wait for ack (used only with the optional feature)

Ports:
- clk  in  1  clock
- xrst  in  1  asynchronous active-low reset
- cfg_we  in  1  descriptor field write strobe
- cfg_layer  in  LAYERLOG  descriptor index
- cfg_field  in  3  field select: 0 in_offset, 1 out_offset, 2 net_offset, 3 total_in, 4 total_out, 5 img_size, 6 conv_size, 7 pool_size
- cfg_wdata  in  16  field value; LSB-aligned, truncated to field width
- num_layers  in  LAYERLOG+1  layers to run (0..LAYERS)
- start  in  1  run request pulse
- ack  in  1  layer-complete pulse from controller
- req  out  1  layer start pulse to controller
- in_offset  out  IMGSIZE  current layer input base
- out_offset  out  IMGSIZE  current layer output base
- net_offset  out  NETSIZE  current layer weight base
- total_in, total_out, img_size, conv_size, pool_size  out  LWIDTH each  current layer sizes
- layer_idx  out  LAYERLOG  index of layer in progress
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when run completes
- err  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset: FSM to IDLE; req, busy, done, err, layer_idx and all config outputs = 0. Descriptor table is not reset; contents are undefined until written.
- Table writes are accepted only in IDLE. cfg_we while busy is ignored and the table is unchanged.
- FSM states: IDLE, LOAD, REQ, WAIT, FIN.
- IDLE: on start with num_layers > 0, latch num_layers, set layer_idx = 0 and busy = 1, go to LOAD.
- IDLE, num_layers = 0: start yields a done pulse on the next cycle; busy stays 0 and no req is issued.
- IDLE, num_layers > LAYERS: clamp to LAYERS.
- LOAD: register all eight fields of descriptor layer_idx onto the config outputs, go to REQ. Outputs stay stable from LOAD until the next LOAD.
- REQ: req = 1 for exactly one cycle, go to WAIT.
- WAIT: hold. When ack arrives, either increment layer_idx and go to LOAD, or, if layer_idx is the last layer, go to FIN.
- FIN: done = 1 for one cycle; busy drops in the same cycle. Go to IDLE. layer_idx and config outputs hold their last values.
- Timing: start in cycle 0 gives LOAD in cycle 1 and req in cycle 2. An ack in cycle n gives the next req in cycle n+2. For the final layer, an ack in cycle n gives done in cycle n+1.
- Ignored events: ack outside WAIT; start while busy. An ack arriving in the same cycle as req cannot occur (ack is only sampled in WAIT).
- Asynchronous reset mid-run aborts immediately to the reset state.

Optional Feature:
- Macro: RENKON_SEQ_TIMEOUT_EN.
- Enabled: a 16-bit counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT without ack, set err (sticky until reset or next accepted start), pulse done, clear busy, and return to IDLE.
- Disabled: no counter; WAIT holds indefinitely and err is constant 0.

Test Plan:
- Write layer0 in_offset=0x010, img_size=12, pool_size=2. Set num_layers=1, start at cycle 0 -> in_offset=0x010 and img_size=12 by cycle 2; req pulse in cycle 2. Ack at cycle 20 -> done at 21, busy low at 21.
- num_layers=3 with distinct net_offset 0x000/0x100/0x200, ack 10 cycles after each req -> exactly three req pulses, layer_idx 0,1,2, net_offset matching each layer; one done pulse.
- num_layers=0, start -> done pulse next cycle, no req, busy never high.
- Mid-run: cfg_we to layer1 plus a second start, then spurious ack while in LOAD -> table unchanged, no extra req, sequence unaffected.
- xrst low while in WAIT of layer 1 -> all outputs 0 immediately. A subsequent start runs from layer 0.
- RENKON_SEQ_TIMEOUT_EN with TIMEOUT=50, no ack -> err=1 and done pulse 50 cycles after WAIT entry; next start clears err.
